// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin mux arbiter.
// Vectors are padded to MAX_N bits so one function serves every N_IN.
package rr_mux_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_N     = 16;

  function automatic logic [MAX_N-1:0] rotr(
    input logic [MAX_N-1:0] v,
    input int unsigned      off,
    input int unsigned      n
  );
    logic [MAX_N-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < n; i++)
      res[i] = v[(i + off) % n];
    return res;
  endfunction

  function automatic logic [3:0] oh2idx(
    input logic [MAX_N-1:0] oh
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) idx |= 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first requester after last_grant,
// wrapping modulo N_IN.
module rr_priority_picker
  import rr_mux_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  localparam int SRC_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SRC_W-1:0] last_grant,
  output logic [N_IN-1:0]  grant_onehot,
  output logic [SRC_W-1:0] grant_idx
);

  int unsigned      off;
  int unsigned      pick;
  logic             found;
  logic [MAX_N-1:0] rot;
  logic [N_IN-1:0]  oh;

  always_comb begin
    off   = 0;
    pick  = 0;
    found = 1'b0;
    oh    = '0;
    if (int'(last_grant) < N_IN - 1)
      off = int'(last_grant) + 1;
    rot = rotr(MAX_N'(req), off, N_IN);
    for (int unsigned j = 0; j < N_IN; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pick  = (j + off) % N_IN;
      end
    end
    if (found) oh[pick] = 1'b1;
  end

  assign grant_onehot = oh;
  assign grant_idx    = SRC_W'(oh2idx(MAX_N'(oh)));

endmodule

// File: rtl/rr_mux_arbiter.sv
// Registered N-to-1 mux with round-robin source selection and
// valid/ready handshakes on every input and on the output.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SRC_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRC_W-1:0]      out_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0] out_src_q, out_src_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;

  logic             load_en;
  logic             accept;
  logic [N_IN-1:0]  grant_oh;
  logic [SRC_W-1:0] grant_idx;

  rr_priority_picker #(
    .N_IN (N_IN)
  ) u_picker (
    .req          (in_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (grant_oh),
    .grant_idx    (grant_idx)
  );

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n) in_ready = grant_oh & {N_IN{load_en}};
  end

  assign accept = |in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = in_data[grant_idx*WIDTH +: WIDTH];
      out_src_d    = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Reset points last_grant at the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SRC_W'(N_IN - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Registered N-to-1 multiplexer stage with a valid/ready handshake on every input and on the output.
- A round-robin arbiter chooses the source. The selected word goes into a one-entry output register.
- It sits upstream of the single-bit and word muxes in the datapath. It turns several producers into one ordered stream and reports which source each word came from.

Parameters:
- N_IN, 4, number of input channels; legal values 2..16.
- WIDTH, 8, data width per channel in bits.
- SRC_W, $clog2(N_IN), width of the source index (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock, the only clock in the block.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  N_IN  bit i: channel i presents a word.
- in_ready  output  N_IN  bit i: channel i's word is accepted this cycle; at most one bit high.
- in_data  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  registered word.
- out_src  output  SRC_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low at a clock edge) sets out_valid=0, out_data=0, out_src=0 and last_grant=N_IN-1, so channel 0 has top priority first.
- While rst_n is low, in_ready is all zeros. Any transfer in flight is dropped.
- A transfer on a side happens when valid and ready are both high at a clock edge.
- load_en = !out_valid || out_ready. The output register takes a word when it is empty, or when it is being drained in the same cycle.
- Grant is combinational:
  - Search channels last_grant+1, last_grant+2, … wrapping modulo N_IN.
  - The first channel with in_valid high wins.
  - in_ready[win] = load_en. All other in_ready bits are 0.
- Rules for in_ready:
  - It may depend combinationally on in_valid and out_ready.
  - It must not depend on in_data.
- On an accepted input at channel k:
  - Next edge: out_data=in_data[k], out_src=k, out_valid=1, last_grant=k.
  - Latency is one cycle from input handshake to out_valid.
- No input accepted and out_ready & out_valid: out_valid goes to 0. out_data and out_src hold their old values.
- Stall (out_valid=1, out_ready=0): out_data, out_src and out_valid hold. in_ready is all zeros.
- Throughput: one word per cycle while out_ready stays high.
- Fairness: a channel that holds in_valid high is granted within N_IN accepted transfers.
- last_grant changes only on an accepted input. Idle cycles do not rotate priority.
- Wrap-around: after last_grant=N_IN-1 the search starts at channel 0.
- Single requester: it is granted every cycle that load_en is high; no bubbles are inserted.
- A producer may drop in_valid without a handshake. The arbiter keeps no memory of requests that were not granted.
- Simultaneous drain and load in one cycle: the new word replaces the old one and out_valid stays 1.

Decomposition:
- Package rr_mux_pkg holds:
  - the default N_IN and WIDTH;
  - a function that rotates a request vector by an offset;
  - a function that converts one-hot to an index.
- Sub-module rr_priority_picker (combinational):
  - inputs: req[N_IN] and last_grant;
  - outputs: grant_onehot and grant_idx.
- The top level holds only the output register, last_grant and the handshake logic.

Test Plan:
- Reset with all in_valid high: while rst_n=0, in_ready=0000 and out_valid=0. First edge after release grants channel 0; next cycle out_src=0.
- All four channels valid, out_ready held 1, data i=8'hA0+i: out_src sequence is 0,1,2,3,0,… and out_data sequence is A0,A1,A2,A3,A0. No gaps.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=A2. out_data stays A2 and in_ready=0000 throughout. After release the next word is from channel 3.
- Wrap and skip: last_grant=2, only channels 1 and 3 valid. Channel 3 is granted, then channel 1.
- Sparse single requester: only channel 2 valid for 5 cycles, out_ready=1. Five words arrive with out_src=2 and no bubbles. Dropping in_valid gives out_valid=0 one cycle later.
- Mid-stream reset: rst_n pulsed low for one cycle while out_valid=1. Next cycle out_valid=0 and out_data=0, and the next grant goes to channel 0.
